// File: rtl/param_serializer.sv
// param_serializer: framed parallel-to-serial transmitter with optional
// parity, selectable bit order and a programmable bit period.
module param_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              parity;
    logic              next_bit;
    logic              bit_end;

    assign bit_end   = (clk_cnt == CLK_LAST);
    assign din_ready = (state == IDLE) && resetn;
    assign busy      = (state != IDLE);

    always_comb begin
        next_bit  = shreg[0];
        shreg_nxt = shreg >> 1;
        if (MSB_FIRST != 0) begin
            next_bit  = shreg[DATA_W-1];
            shreg_nxt = shreg << 1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            sout       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE)
                clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
            unique case (state)
                IDLE: begin
                    if (din_valid) begin
                        state   <= START;
                        shreg   <= din;
                        // parity is taken from the captured word, not the live bus
                        parity  <= (^din) ^ (PARITY_ODD != 0);
                        sout    <= 1'b0;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        sout  <= next_bit;
                        shreg <= shreg_nxt;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                sout  <= parity;
                            end else begin
                                state <= STOP;
                                sout  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            sout    <= next_bit;
                            shreg   <= shreg_nxt;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        sout  <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_serializer.sv
// tb_param_serializer: scoreboard bench over four parameter sets of
// param_serializer, comparing sout/busy/frame_done/din_ready per cycle.
`timescale 1ns/1ps
module tb_param_serializer;

    typedef struct packed {
        logic s;
        logic b;
        logic f;
        logic r;
    } exp_t;

    localparam int DW   [4] = '{8, 8, 8, 4};
    localparam int CPB  [4] = '{1, 1, 1, 4};
    localparam int MSB  [4] = '{1, 0, 0, 1};
    localparam int PEN  [4] = '{0, 1, 1, 0};
    localparam int PODD [4] = '{0, 0, 1, 0};
    localparam int STB  [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [4];
    logic       dv  [4];
    logic       rdy [4];
    logic       so  [4];
    logic       bsy [4];
    logic       fd  [4];

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #10 clk = ~clk;

    param_serializer #(
        .DATA_W(DW[0]), .CLKS_PER_BIT(CPB[0]), .MSB_FIRST(MSB[0]),
        .PARITY_EN(PEN[0]), .PARITY_ODD(PODD[0]), .STOP_BITS(STB[0])
    ) u0 (
        .CLOCK_50(clk), .resetn(rst_n), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .sout(so[0]), .busy(bsy[0]), .frame_done(fd[0])
    );

    param_serializer #(
        .DATA_W(DW[1]), .CLKS_PER_BIT(CPB[1]), .MSB_FIRST(MSB[1]),
        .PARITY_EN(PEN[1]), .PARITY_ODD(PODD[1]), .STOP_BITS(STB[1])
    ) u1 (
        .CLOCK_50(clk), .resetn(rst_n), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .sout(so[1]), .busy(bsy[1]), .frame_done(fd[1])
    );

    param_serializer #(
        .DATA_W(DW[2]), .CLKS_PER_BIT(CPB[2]), .MSB_FIRST(MSB[2]),
        .PARITY_EN(PEN[2]), .PARITY_ODD(PODD[2]), .STOP_BITS(STB[2])
    ) u2 (
        .CLOCK_50(clk), .resetn(rst_n), .din(din[2]), .din_valid(dv[2]),
        .din_ready(rdy[2]), .sout(so[2]), .busy(bsy[2]), .frame_done(fd[2])
    );

    param_serializer #(
        .DATA_W(DW[3]), .CLKS_PER_BIT(CPB[3]), .MSB_FIRST(MSB[3]),
        .PARITY_EN(PEN[3]), .PARITY_ODD(PODD[3]), .STOP_BITS(STB[3])
    ) u3 (
        .CLOCK_50(clk), .resetn(rst_n), .din(din[3][3:0]), .din_valid(dv[3]),
        .din_ready(rdy[3]), .sout(so[3]), .busy(bsy[3]), .frame_done(fd[3])
    );

    function automatic exp_t mk(input logic s, input logic b,
                                input logic f, input logic r);
        exp_t e;
        e = {s, b, f, r};
        return e;
    endfunction

    // One queue entry per clock cycle, starting with the cycle after accept.
    task automatic push_frame(input int d, input logic [7:0] w);
        logic p;
        int   idx;
        p = 1'b0;
        for (int i = 0; i < DW[d]; i++) p = p ^ w[i];
        if (PODD[d] != 0) p = ~p;
        for (int k = 0; k < CPB[d]; k++) sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < DW[d]; i++) begin
            idx = (MSB[d] != 0) ? DW[d] - 1 - i : i;
            for (int k = 0; k < CPB[d]; k++) sb.push_back(mk(w[idx], 1'b1, 1'b0, 1'b0));
        end
        if (PEN[d] != 0)
            for (int k = 0; k < CPB[d]; k++) sb.push_back(mk(p, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < STB[d] * CPB[d]; k++) sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            compared++;
            if ({so[d], bsy[d], fd[d], rdy[d]} !== 4'b1000) begin
                mismatched++;
                $display("FAIL reset_held d%0d: got sbfr=%b%b%b%b expected 1000",
                         d, so[d], bsy[d], fd[d], rdy[d]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            compared++;
            if ({so[d], bsy[d], fd[d], rdy[d]} !== 4'b1001) begin
                mismatched++;
                $display("FAIL reset_release d%0d: got sbfr=%b%b%b%b expected 1001",
                         d, so[d], bsy[d], fd[d], rdy[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] ws [3];
        exp_t e;
        int cyc;
        ws = '{8'hA9, 8'h00, 8'hFF};
        foreach (ws[j]) begin
            @(negedge clk);
            din[0] = ws[j];
            dv[0]  = 1'b1;
            push_frame(0, ws[j]);
            @(posedge clk);
            #1 dv[0] = 1'b0;
            cyc = 0;
            while (sb.size() > 0) begin
                @(negedge clk);
                e = sb.pop_front();
                compared++;
                if ({so[0], bsy[0], fd[0], rdy[0]} !== e) begin
                    mismatched++;
                    $display("FAIL basic w=%h cyc %0d: got sbfr=%b%b%b%b expected %b",
                             ws[j], cyc, so[0], bsy[0], fd[0], rdy[0], e);
                end
                din[0] = 8'($urandom);
                dv[0]  = e.r ? 1'b0 : 1'($urandom);
                cyc++;
            end
        end
    endtask

    task automatic test_parity();
        int         ds [4];
        logic [7:0] ws [4];
        exp_t e;
        int cyc;
        int d;
        ds = '{1, 2, 1, 2};
        ws = '{8'hA9, 8'hA9, 8'h07, 8'h07};
        foreach (ws[j]) begin
            d = ds[j];
            @(negedge clk);
            din[d] = ws[j];
            dv[d]  = 1'b1;
            push_frame(d, ws[j]);
            @(posedge clk);
            #1 dv[d] = 1'b0;
            cyc = 0;
            while (sb.size() > 0) begin
                @(negedge clk);
                e = sb.pop_front();
                compared++;
                if ({so[d], bsy[d], fd[d], rdy[d]} !== e) begin
                    mismatched++;
                    $display("FAIL parity d%0d w=%h cyc %0d: got sbfr=%b%b%b%b expected %b",
                             d, ws[j], cyc, so[d], bsy[d], fd[d], rdy[d], e);
                end
                din[d] = 8'($urandom);
                dv[d]  = e.r ? 1'b0 : 1'($urandom);
                cyc++;
            end
        end
    endtask

    task automatic test_slow();
        logic [7:0] ws [2];
        exp_t e;
        int cyc;
        ws = '{8'h06, 8'h09};
        foreach (ws[j]) begin
            @(negedge clk);
            din[3] = ws[j];
            dv[3]  = 1'b1;
            push_frame(3, ws[j]);
            @(posedge clk);
            #1 dv[3] = 1'b0;
            cyc = 0;
            while (sb.size() > 0) begin
                @(negedge clk);
                e = sb.pop_front();
                compared++;
                if ({so[3], bsy[3], fd[3], rdy[3]} !== e) begin
                    mismatched++;
                    $display("FAIL slow w=%h cyc %0d: got sbfr=%b%b%b%b expected %b",
                             ws[j], cyc, so[3], bsy[3], fd[3], rdy[3], e);
                end
                din[3] = 8'($urandom);
                dv[3]  = e.r ? 1'b0 : 1'($urandom);
                cyc++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        int cyc;
        int fd_seen;
        n = 0;
        cyc = 0;
        fd_seen = 0;
        @(negedge clk);
        din[0] = 8'h00;
        dv[0]  = 1'b1;
        push_frame(0, 8'h00);
        n = 1;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            compared++;
            if ({so[0], bsy[0], fd[0], rdy[0]} !== e) begin
                mismatched++;
                $display("FAIL back_to_back cyc %0d: got sbfr=%b%b%b%b expected %b",
                         cyc, so[0], bsy[0], fd[0], rdy[0], e);
            end
            if (fd[0] === 1'b1) fd_seen++;
            if (sb.size() == 0 && n < 4) begin
                din[0] = n[0] ? 8'hFF : 8'h00;
                push_frame(0, din[0]);
                n++;
            end else if (sb.size() == 0) begin
                dv[0] = 1'b0;
            end else begin
                din[0] = 8'($urandom);
            end
            cyc++;
        end
        compared++;
        if (fd_seen !== 4) begin
            mismatched++;
            $display("FAIL back_to_back_frames: got %0d frame_done pulses expected 4", fd_seen);
        end
    endtask

    task automatic test_midframe_reset();
        exp_t e;
        int cyc;
        @(negedge clk);
        din[0] = 8'h5C;
        dv[0]  = 1'b1;
        push_frame(0, 8'h5C);
        @(posedge clk);
        #1 dv[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            compared++;
            if ({so[0], bsy[0], fd[0], rdy[0]} !== e) begin
                mismatched++;
                $display("FAIL midreset_pre cyc %0d: got sbfr=%b%b%b%b expected %b",
                         c, so[0], bsy[0], fd[0], rdy[0], e);
            end
        end
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({so[0], bsy[0], fd[0], rdy[0]} !== 4'b1000) begin
            mismatched++;
            $display("FAIL midreset_async: got sbfr=%b%b%b%b expected 1000",
                     so[0], bsy[0], fd[0], rdy[0]);
        end
        repeat (2) begin
            @(negedge clk);
            compared++;
            if ({so[0], bsy[0], fd[0], rdy[0]} !== 4'b1000) begin
                mismatched++;
                $display("FAIL midreset_held: got sbfr=%b%b%b%b expected 1000",
                         so[0], bsy[0], fd[0], rdy[0]);
            end
        end
        @(negedge clk);
        rst_n  = 1'b1;
        din[0] = 8'h3C;
        dv[0]  = 1'b1;
        push_frame(0, 8'h3C);
        @(posedge clk);
        #1 dv[0] = 1'b0;
        cyc = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            compared++;
            if ({so[0], bsy[0], fd[0], rdy[0]} !== e) begin
                mismatched++;
                $display("FAIL midreset_after cyc %0d: got sbfr=%b%b%b%b expected %b",
                         cyc, so[0], bsy[0], fd[0], rdy[0], e);
            end
            din[0] = 8'($urandom);
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            din[d] = 8'h00;
            dv[d]  = 1'b0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_slow();
        test_back_to_back();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
